byte_serial_adder: RTL and testbench



---
 rtl/byte_serial_adder.sv | 180 ++++++++++++++++++
 tb/tb_byte_serial_adder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serial_adder.sv
// byte_serial_adder: WIDTH-bit add/subtract streamed one byte per cycle
// through a single 8-bit Kogge-Stone adder with a registered carry chain.

module kogge_stone_adder8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] S,
    output logic       Cout
);

    logic [7:0] g0, p0, g1, p1, g2, p2, g3, p3;
    logic [8:0] c;

    assign g0 = A & B;
    assign p0 = A ^ B;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_prefix
            if (i >= 1) begin : g_d1
                assign g1[i] = g0[i] | (p0[i] & g0[i-1]);
                assign p1[i] = p0[i] & p0[i-1];
            end else begin : g_d1_pass
                assign g1[i] = g0[i];
                assign p1[i] = p0[i];
            end
            if (i >= 2) begin : g_d2
                assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
                assign p2[i] = p1[i] & p1[i-2];
            end else begin : g_d2_pass
                assign g2[i] = g1[i];
                assign p2[i] = p1[i];
            end
            if (i >= 4) begin : g_d4
                assign g3[i] = g2[i] | (p2[i] & g2[i-4]);
                assign p3[i] = p2[i] & p2[i-4];
            end else begin : g_d4_pass
                assign g3[i] = g2[i];
                assign p3[i] = p2[i];
            end
            // Group [i:0] folded with the incoming carry.
            assign c[i+1] = g3[i] | (p3[i] & Cin);
        end
    endgenerate

    assign c[0] = Cin;
    assign S    = p0 ^ c[7:0];
    assign Cout = c[8];

endmodule

module byte_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / 8;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                carry_q, carry_d;
    logic [N-1:0][7:0]   a_q, a_d;
    logic [N-1:0][7:0]   b_q, b_d;
    logic [N-1:0][7:0]   sum_q, sum_d;
    logic                cout_q, cout_d;
    logic                ovf_q, ovf_d;
    logic                zero_q, zero_d;

    logic [7:0]          ks_a, ks_b, ks_s;
    logic                ks_cout;

    assign ks_a = a_q[idx_q];
    assign ks_b = b_q[idx_q];

    kogge_stone_adder8bit u_ks (
        .A    (ks_a),
        .B    (ks_b),
        .Cin  (carry_q),
        .S    (ks_s),
        .Cout (ks_cout)
    );

    // Next-state, operand capture and per-byte result accumulation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = ks_s;
                carry_d      = ks_cout;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    cout_d  = ks_cout;
                    ovf_d   = (a_q[N-1][7] == b_q[N-1][7]) &&
                              (ks_s[7] != a_q[N-1][7]);
                    zero_d  = ~|sum_d;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// tb_byte_serial_adder: directed and randomized checks of byte_serial_adder
// at WIDTH=8, 32 and 64 against an arithmetic reference model.

module tb_byte_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] a, b;
    logic        sub;
    logic [2:0]  in_valid, out_ready;
    logic [2:0]  in_ready, out_valid, cout, ovf, zero;
    logic [7:0]  s8;
    logic [31:0] s32;
    logic [63:0] s64;
    logic [63:0] sum_v [3];

    int n_checks = 0;
    int n_fail   = 0;

    assign sum_v[0] = {56'd0, s8};
    assign sum_v[1] = {32'd0, s32};
    assign sum_v[2] = s64;

    always #5 clk = ~clk;

    byte_serial_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[7:0]), .b(b[7:0]), .sub(sub),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(s8), .cout(cout[0]), .ovf(ovf[0]), .zero(zero[0])
    );

    byte_serial_adder #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[31:0]), .b(b[31:0]), .sub(sub),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(s32), .cout(cout[1]), .ovf(ovf[1]), .zero(zero[1])
    );

    byte_serial_adder #(.WIDTH(64)) u_w64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .sub(sub),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(s64), .cout(cout[2]), .ovf(ovf[2]), .zero(zero[2])
    );

    // One complete operation on instance k with optional DONE backpressure
    // and scrambling of the inputs while the operation is in flight.
    task automatic run_op(input int k, input logic [63:0] av,
                          input logic [63:0] bv, input logic sv,
                          input int hold, input bit scramble);
        int          w, n, lat;
        logic [64:0] mask, full;
        logic [63:0] am, bm, exp_sum, held;
        logic        ec, eo, ez, sa, sb, sr;
        w    = (k == 0) ? 8 : (k == 1) ? 32 : 64;
        n    = w / 8;
        mask = (65'd1 << w) - 65'd1;
        am   = av & mask[63:0];
        bm   = bv & mask[63:0];
        if (sv)
            full = {1'b0, am} + {1'b0, ~bm & mask[63:0]} + 65'd1;
        else
            full = {1'b0, am} + {1'b0, bm};
        exp_sum = full[63:0] & mask[63:0];
        ec = full[w];
        sa = am[w-1];
        sb = bm[w-1];
        sr = exp_sum[w-1];
        eo = sv ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        ez = (exp_sum == 64'd0);

        n_checks++;
        if (in_ready[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_in_ready k=%0d got=%b exp=1", k, in_ready[k]);
        end

        a = av; b = bv; sub = sv;
        in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;

        lat = 0;
        while (out_valid[k] !== 1'b1 && lat < 200) begin
            if (scramble) begin
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                sub = 1'($urandom);
                in_valid[k] = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat != n) begin
            n_fail++;
            $display("FAIL latency k=%0d got=%0d exp=%0d", k, lat, n);
        end

        n_checks++;
        if (sum_v[k] !== exp_sum || cout[k] !== ec ||
            ovf[k] !== eo || zero[k] !== ez) begin
            n_fail++;
            $display("FAIL result k=%0d a=%h b=%h sub=%b got sum=%h c=%b v=%b z=%b exp sum=%h c=%b v=%b z=%b",
                     k, am, bm, sv, sum_v[k], cout[k], ovf[k], zero[k],
                     exp_sum, ec, eo, ez);
        end

        held = sum_v[k];
        for (int i = 0; i < hold; i++) begin
            if (scramble) begin
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                in_valid[k] = 1'($urandom);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid[k] !== 1'b1 || in_ready[k] !== 1'b0 ||
                sum_v[k] !== held) begin
                n_fail++;
                $display("FAIL backpressure k=%0d cyc=%0d got v=%b r=%b sum=%h exp v=1 r=0 sum=%h",
                         k, i, out_valid[k], in_ready[k], sum_v[k], held);
            end
        end

        in_valid[k] = 1'b0;
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        n_checks++;
        if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 ||
            sum_v[k] !== exp_sum || cout[k] !== ec) begin
            n_fail++;
            $display("FAIL release k=%0d got r=%b v=%b sum=%h c=%b exp r=1 v=0 sum=%h c=%b",
                     k, in_ready[k], out_valid[k], sum_v[k], cout[k],
                     exp_sum, ec);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = '0; out_ready = '0;
        a = '0; b = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 ||
                sum_v[k] !== 64'd0 || cout[k] !== 1'b0 ||
                ovf[k] !== 1'b0 || zero[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset k=%0d got r=%b v=%b sum=%h c=%b o=%b z=%b exp r=1 v=0 all zero",
                         k, in_ready[k], out_valid[k], sum_v[k],
                         cout[k], ovf[k], zero[k]);
            end
        end
    endtask

    task automatic test_add_carry();
        run_op(1, 64'hFFFF_FFFF, 64'h1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_sub_borrow();
        run_op(1, 64'h5, 64'h7, 1'b1, 0, 1'b0);
        run_op(1, 64'h1234, 64'h1234, 1'b1, 0, 1'b0);
        run_op(1, 64'h9, 64'h0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_overflow();
        run_op(1, 64'h7FFF_FFFF, 64'h1, 1'b0, 0, 1'b0);
        run_op(1, 64'h8000_0000, 64'h1, 1'b1, 0, 1'b0);
        run_op(0, 64'h80, 64'h80, 1'b0, 0, 1'b0);
        run_op(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               1'b1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_op(1, 64'hDEAD_BEEF, 64'h0102_0304, 1'b0, 10, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        a = 64'h1234_5678; b = 64'h1111_1111; sub = 1'b0;
        in_valid[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 ||
            sum_v[1] !== 64'd0 || cout[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got v=%b r=%b sum=%h c=%b exp v=0 r=1 sum=0 c=0",
                     out_valid[1], in_ready[1], sum_v[1], cout[1]);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL discarded_op cyc=%0d got v=%b exp v=0",
                         i, out_valid[1]);
            end
        end
        run_op(1, 64'h1234_5678, 64'h1111_1111, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] av, bv;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 25; i++) begin
                av = {$urandom, $urandom};
                bv = ($urandom_range(0, 4) == 0) ? av : {$urandom, $urandom};
                run_op(k, av, bv, 1'($urandom), $urandom_range(0, 3), 1'b1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_sub_borrow();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
